// File: rtl/ixc_assign_pipe.sv
// ixc_assign_pipe: elastic carrier for a WIDTH-bit R->L word through STAGES register slices.
// Optional per-lane parity protection is built when IXC_ASSIGN_PIPE_PARITY_EN is defined.
module ixc_assign_pipe #(
  parameter int WIDTH  = 384,
  parameter int STAGES = 2,
  localparam int CW    = (STAGES < 1) ? 1 : $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] R,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [WIDTH-1:0] L,
  output logic             l_valid,
  input  logic             l_ready,
  input  logic             flush,
  output logic [CW-1:0]    occ,
  output logic             par_err
);

  // Handshake: a beat crosses a side at each rising edge where that side's valid and ready
  // are both 1; a source never withdraws or changes a beat while valid=1 and ready=0.

`ifdef IXC_ASSIGN_PIPE_PARITY_EN
  localparam int NL = (WIDTH + 31) / 32;

  // Even parity per 32-bit lane; the top lane is zero-padded.
  function automatic logic [NL-1:0] lane_parity(input logic [WIDTH-1:0] w);
    logic [NL*32-1:0] wp;
    logic [NL-1:0]    p;
    wp = (NL * 32)'(w);
    for (int k = 0; k < NL; k++) begin
      p[k] = ^wp[k*32 +: 32];
    end
    return p;
  endfunction
`endif

  if (STAGES == 0) begin : g_wire
    assign L       = R;
    assign l_valid = r_valid & ~flush;
    assign r_ready = l_ready & ~flush;
    assign occ     = '0;
    assign par_err = 1'b0;
  end else begin : g_pipe
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [CW-1:0]     occ_q;
    logic [CW-1:0]     occ_d;

    // A stage is ready unless it and every stage after it is full while the sink stalls.
    always_comb begin
      logic full_tail;
      full_tail = 1'b1;
      rdy       = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
        full_tail = full_tail & v_q[i];
        rdy[i]    = ~full_tail | l_ready;
      end
    end

    always_comb begin
      v_d   = v_q;
      ld    = '0;
      occ_d = '0;
      ld[0] = rdy[0] & r_valid & ~flush;
      if (rdy[0]) v_d[0] = r_valid & ~flush;
      for (int i = 1; i < STAGES; i++) begin
        ld[i] = rdy[i] & v_q[i-1] & ~flush;
        if (rdy[i]) v_d[i] = v_q[i-1];
      end
      if (flush) v_d = '0;
      for (int i = 0; i < STAGES; i++) begin
        occ_d = occ_d + CW'(v_d[i]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= '0;
        occ_q <= '0;
        for (int i = 0; i < STAGES; i++) begin
          d_q[i] <= '0;
        end
      end else begin
        v_q   <= v_d;
        occ_q <= occ_d;
        if (ld[0]) d_q[0] <= R;
        for (int i = 1; i < STAGES; i++) begin
          if (ld[i]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign L       = d_q[STAGES-1];
    assign l_valid = v_q[STAGES-1];
    // Gating with rst_n keeps the source stalled for the whole reset window.
    assign r_ready = rdy[0] & ~flush & rst_n;
    assign occ     = occ_q;

`ifdef IXC_ASSIGN_PIPE_PARITY_EN
    logic [NL-1:0] p_q [STAGES];
    logic          par_err_q;

    // Lane parities share the data load enables so they stay attached to their beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        par_err_q <= 1'b0;
        for (int i = 0; i < STAGES; i++) begin
          p_q[i] <= '0;
        end
      end else begin
        if (ld[0]) p_q[0] <= lane_parity(R);
        for (int i = 1; i < STAGES; i++) begin
          if (ld[i]) p_q[i] <= p_q[i-1];
        end
        if (v_q[STAGES-1] & l_ready & (lane_parity(d_q[STAGES-1]) != p_q[STAGES-1])) begin
          par_err_q <= 1'b1;
        end
      end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Bench for ixc_assign_pipe: WIDTH=384/STAGES=2 pipe against a beat-queue model, plus a
// WIDTH=8/STAGES=0 pass-through instance. Parity scenario builds with IXC_ASSIGN_PIPE_PARITY_EN.
module tb_ixc_assign_pipe;
  localparam int W  = 384;
  localparam int S  = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  R;
  logic [W-1:0]  L;
  logic          r_valid, r_ready, l_valid, l_ready, flush, par_err;
  logic [CW-1:0] occ;

  logic [7:0]    R0, L0;
  logic          r_valid0, r_ready0, l_valid0, l_ready0, flush0, par_err0;
  logic [0:0]    occ0;

  int checks = 0;
  int errors = 0;

  // Reference model: beats in flight, oldest first, with edges elapsed since acceptance.
  logic [W-1:0] exp_q[$];
  int           age_q[$];
  logic         m_r_ready, m_l_valid;
  int           m_occ;

  ixc_assign_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .R(R), .r_valid(r_valid), .r_ready(r_ready),
    .L(L), .l_valid(l_valid), .l_ready(l_ready), .flush(flush), .occ(occ), .par_err(par_err)
  );

  ixc_assign_pipe #(.WIDTH(8), .STAGES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .R(R0), .r_valid(r_valid0), .r_ready(r_ready0),
    .L(L0), .l_valid(l_valid0), .l_ready(l_ready0), .flush(flush0), .occ(occ0), .par_err(par_err0)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Driver: apply inputs after the falling edge and form the model's expectations.
  // The oldest beat never meets a stall before the last stage, so it reaches L after S-1 edges.
  task automatic drive(input logic rv, input logic [W-1:0] d, input logic lr, input logic fl);
    @(negedge clk);
    r_valid = rv;
    R       = d;
    l_ready = lr;
    flush   = fl;
    #1;
    m_r_ready = !fl && ((exp_q.size() < S) || lr);
    m_l_valid = (exp_q.size() > 0) && (age_q[0] >= S - 1);
    m_occ     = exp_q.size();
  endtask

  task automatic advance();
    logic rx, lx;
    rx = r_valid && m_r_ready;
    lx = m_l_valid && l_ready;
    @(posedge clk);
    if (lx) begin
      void'(exp_q.pop_front());
      void'(age_q.pop_front());
    end
    foreach (age_q[i]) age_q[i] = age_q[i] + 1;
    if (flush) begin
      exp_q.delete();
      age_q.delete();
    end
    if (rx) begin
      exp_q.push_back(R);
      age_q.push_back(0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; r_valid = 1'b0; R = '0; l_ready = 1'b0; flush = 1'b0;
    R0 = '0; r_valid0 = 1'b0; l_ready0 = 1'b0; flush0 = 1'b0;
    exp_q.delete();
    age_q.delete();
    repeat (2) @(negedge clk);
    checks++; if (L !== '0) begin errors++; $display("FAIL reset_L got %0h exp 0", L); end
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL reset_l_valid got %b exp 0", l_valid); end
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL reset_r_ready got %b exp 0", r_ready); end
    checks++; if (occ !== '0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occ); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b exp 0", par_err); end
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL release_r_ready got %b exp 1", r_ready); end
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL release_l_valid got %b exp 0", l_valid); end
    checks++; if (occ !== '0) begin errors++; $display("FAIL release_occ got %0d exp 0", occ); end
    advance();
  endtask

  task automatic test_streaming();
    logic [W-1:0] want;
    for (int c = 0; c < 6; c++) begin
      drive(c < 3, W'(c + 1), 1'b1, 1'b0);
      if (c >= 2 && c <= 4) begin
        want = W'(c - 1);
        checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL stream_l_valid c%0d got %b exp 1", c, l_valid); end
        checks++; if (L !== want) begin errors++; $display("FAIL stream_L c%0d got %0h exp %0h", c, L, want); end
      end
      if (c == 2 || c == 3) begin
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL stream_occ c%0d got %0d exp 2", c, occ); end
      end
      advance();
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] beats [3];
    int sent = 0;
    int got  = 0;
    for (int i = 0; i < 3; i++) beats[i] = rand_word();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, beats[sent], 1'b0, 1'b0);
      if (c >= 2) begin
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL bp_occ c%0d got %0d exp 2", c, occ); end
        checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL bp_r_ready c%0d got %b exp 0", c, r_ready); end
        checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL bp_l_valid c%0d got %b exp 1", c, l_valid); end
        checks++; if (L !== beats[0]) begin errors++; $display("FAIL bp_hold_L c%0d got %0h exp %0h", c, L, beats[0]); end
      end
      if (m_r_ready) sent++;
      advance();
    end
    for (int c = 0; c < 10 && got < 3; c++) begin
      drive(sent < 3, (sent < 3) ? beats[sent] : '0, 1'b1, 1'b0);
      if (l_valid === 1'b1) begin
        checks++; if (L !== beats[got]) begin errors++; $display("FAIL bp_order beat%0d got %0h exp %0h", got, L, beats[got]); end
        got++;
      end
      if (sent < 3 && m_r_ready) sent++;
      advance();
    end
    checks++; if (got != 3) begin errors++; $display("FAIL bp_drain delivered %0d exp 3", got); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 4 && m_occ < S; c++) begin
      drive(1'b1, rand_word(), 1'b0, 1'b0);
      advance();
    end
    drive(1'b1, rand_word(), 1'b0, 1'b1);
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d exp 2", occ); end
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL flush_r_ready got %b exp 0", r_ready); end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (occ !== '0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occ); end
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL flush_l_valid got %b exp 0", l_valid); end
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL flush_leak c%0d got %b exp 0", c, l_valid); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      checks++; if (r_ready !== m_r_ready) begin errors++; $display("FAIL rand_r_ready c%0d got %b exp %b", c, r_ready, m_r_ready); end
      checks++; if (l_valid !== m_l_valid) begin errors++; $display("FAIL rand_l_valid c%0d got %b exp %b", c, l_valid, m_l_valid); end
      checks++; if (occ !== m_occ[CW-1:0]) begin errors++; $display("FAIL rand_occ c%0d got %0d exp %0d", c, occ, m_occ); end
      if (m_l_valid) begin
        checks++; if (L !== exp_q[0]) begin errors++; $display("FAIL rand_L c%0d got %0h exp %0h", c, L, exp_q[0]); end
      end
      advance();
    end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL rand_par_err got %b exp 0", par_err); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, rand_word(), 1'b0, 1'b0);
      advance();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    age_q.delete();
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL midrst_l_valid got %b exp 0", l_valid); end
    checks++; if (occ !== '0) begin errors++; $display("FAIL midrst_occ got %0d exp 0", occ); end
    checks++; if (L !== '0) begin errors++; $display("FAIL midrst_L got %0h exp 0", L); end
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL midrst_r_ready got %b exp 0", r_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_r_ready got %b exp 1", r_ready); end
    advance();
  endtask

  task automatic test_wire();
    logic [7:0] d;
    logic rv, lr, fl;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        d = 8'hA5; rv = 1'b1; lr = 1'b1; fl = 1'b0;
      end else if (i == 1) begin
        d = 8'hA5; rv = 1'b1; lr = 1'b0; fl = 1'b0;
      end else begin
        d = 8'($urandom); rv = 1'($urandom); lr = 1'($urandom); fl = ($urandom_range(0, 3) == 0);
      end
      R0 = d; r_valid0 = rv; l_ready0 = lr; flush0 = fl;
      #1;
      checks++; if (L0 !== d) begin errors++; $display("FAIL wire_L i%0d got %0h exp %0h", i, L0, d); end
      checks++; if (l_valid0 !== (rv & !fl)) begin errors++; $display("FAIL wire_l_valid i%0d got %b exp %b", i, l_valid0, rv & !fl); end
      checks++; if (r_ready0 !== (lr & !fl)) begin errors++; $display("FAIL wire_r_ready i%0d got %b exp %b", i, r_ready0, lr & !fl); end
      checks++; if (occ0 !== 1'b0) begin errors++; $display("FAIL wire_occ i%0d got %0d exp 0", i, occ0); end
    end
    checks++; if (par_err0 !== 1'b0) begin errors++; $display("FAIL wire_par_err got %b exp 0", par_err0); end
  endtask

`ifdef IXC_ASSIGN_PIPE_PARITY_EN
  task automatic test_parity();
    drive(1'b1, rand_word(), 1'b0, 1'b0);
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    advance();
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_pre got %b exp 0", par_err); end
    dut.g_pipe.d_q[1][7] = ~dut.g_pipe.d_q[1][7];
    drive(1'b0, '0, 1'b1, 1'b0);
    advance();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_sticky c%0d got %b exp 1", c, par_err); end
      advance();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_reset got %b exp 0", par_err); end
    exp_q.delete();
    age_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_random();
    test_reset_mid();
    test_wire();
`ifdef IXC_ASSIGN_PIPE_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
